simd_multiplier: RTL and testbench
==================================

SIMD_MULTIPLIER -- requirements
Module: simd_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have port CLK  input  1  rising-edge clock.
REQ-003 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port a  input  WIDTH  packed multiplicand lanes.
REQ-005 SHALL have port b  input  WIDTH  packed multiplier lanes.
REQ-006 SHALL have port mode  input  2  lane size: 00=2-bit, 01=4-bit, 10=8-bit, 11=8-bit (reserved alias).
REQ-007 SHALL have port in_valid  input  1  a/b/mode valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-009 SHALL have port result  output  2*WIDTH  packed lane products.
REQ-010 SHALL have port out_mode  output  2  mode of the transaction currently on result.
REQ-011 SHALL have port out_valid  output  1  result/out_mode valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-013 SHALL split a and b into WIDTH/L lanes of L bits (L=2,4,8 per mode), lane i = bits [i*L+L-1:i*L].
REQ-014 SHALL place lane i product (2L bits, zero-extended for unsigned) in result[i*2L+2L-1:i*2L]; no carries cross lane boundaries.
REQ-015 SHALL accept a transaction on any rising edge with in_valid=1 and in_ready=1; mode is captured with its operands and travels with them.
REQ-016 SHALL use a 2-stage pipeline: stage 1 registers 2x2-bit partial products, stage 2 registers assembled lane results.
REQ-017 SHALL assert out_valid exactly 2 cycles after acceptance when out_ready stays 1; throughput one transaction per cycle.
REQ-018 SHALL compute in_ready = !v1 | !v2 | out_ready (v1/v2 = stage valid flags), combinationally.
REQ-019 SHALL hold result, out_mode and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL retire a result on an edge with out_valid=1 and out_ready=1; a simultaneous accept and retire SHALL lose and duplicate nothing.
REQ-021 SHALL ignore a/b/mode when in_valid=0 or in_ready=0; no transaction is created.
REQ-022 SHALL preserve in-order delivery; with both stages full and out_ready=0, in_ready SHALL be 0.

Reset
REQ-023 SHALL on nrst=0, immediately and independent of CLK, clear v1, v2, out_valid to 0, result to 0, out_mode to 00.
REQ-024 SHALL discard in-flight transactions when reset asserts mid-operation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-025 SHALL, with SIMD_MULT_SIGNED_EN defined, add port sgn  input  1, captured with operands; sgn=1 treats lanes as two's complement, with 2L-bit sign-extended products.
REQ-026 SHALL, without SIMD_MULT_SIGNED_EN, omit port sgn and treat all lanes as unsigned.

Verification (WIDTH=8)
REQ-027 SHALL check 2-bit mode: a=8'hFF, b=8'hFF, mode=00 -> result=16'h9999, out_valid 2 cycles after accept.
REQ-028 SHALL check 4-bit mode: a=8'h33, b=8'h21, mode=01 -> result=16'h0603.
REQ-029 SHALL check 8-bit mode: a=8'hFF, b=8'hFF, mode=10 -> result=16'hFE01, out_mode=10.
REQ-030 SHALL check back-to-back: 3 consecutive accepts (8'h03x8'h03 mode 10, 8'hFFx8'hFF mode 00, 8'h33x8'h21 mode 01) with out_ready=1 -> 16'h0009, 16'h9999, 16'h0603 on 3 consecutive cycles.
REQ-031 SHALL check backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 after 2 accepts, result held, both results delivered in order once out_ready=1.
REQ-032 SHALL check signed mode (SIMD_MULT_SIGNED_EN): a=8'hFF, b=8'hFF, mode=00, sgn=1 -> result=16'h1111; nrst pulsed mid-flight -> out_valid=0 immediately.

Source files
------------

// File: rtl/simd_multiplier.sv
// simd_multiplier: 2-stage packed SIMD multiplier, 2/4/8-bit lanes selected per transaction.
// Define SIMD_MULT_SIGNED_EN to add the sgn port for two's-complement lanes.
module simd_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               nrst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
`ifdef SIMD_MULT_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [1:0]         out_mode,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int NB = WIDTH / 8;
  logic               s_in;
  logic [NB*64-1:0]   pp_q, pp_d;
  logic [2*WIDTH-1:0] corr_q, corr_d, res_q, res_d;
  logic [1:0]         mode1_q, mode1_d, mode2_q, mode2_d;
  logic               v1_q, v1_d, v2_q, v2_d, adv2, accept;
`ifdef SIMD_MULT_SIGNED_EN
  assign s_in = sgn;
`else
  assign s_in = 1'b0;
`endif
  // Signed lane product = unsigned product - (sa ? B<<L : 0) - (sb ? A<<L : 0), lane-local mod 2^2L
  function automatic logic [2*WIDTH-1:0] corr(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int l);
    logic [WIDTH-1:0]   xw, yw;
    logic [15:0]        xa, ya, s;
    logic [2*WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      if (i < WIDTH / l) begin
        xw = x >> (i * l);
        yw = y >> (i * l);
        xa = 16'(xw[7:0]) & ((16'd1 << l) - 16'd1);
        ya = 16'(yw[7:0]) & ((16'd1 << l) - 16'd1);
        s = 16'd0 - ((xw[l-1] ? ya : 16'd0) + (yw[l-1] ? xa : 16'd0));
        s = (s << l) & ((16'd1 << (2 * l)) - 16'd1);
        c = c | ((2*WIDTH)'(s) << (i * 2 * l));
      end
    end
    return c;
  endfunction
  assign adv2     = !v2_q || out_ready;
  assign in_ready = !v1_q || !v2_q || out_ready;
  assign accept   = in_valid && in_ready;
  always_comb begin
    pp_d    = pp_q;
    corr_d  = corr_q;
    mode1_d = accept ? mode : mode1_q;
    v1_d    = in_ready ? accept : v1_q;
    if (accept) begin
      for (int k = 0; k < NB; k++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            pp_d[((k*4+i)*4+j)*4 +: 4] = 4'(a[k*8+i*2 +: 2]) * 4'(b[k*8+j*2 +: 2]);
      corr_d = !s_in ? '0 : mode[1] ? corr(a, b, 8) : mode[0] ? corr(a, b, 4) : corr(a, b, 2);
    end
  end
  always_comb begin
    logic [15:0] p2, p4, p8, t;
    p2      = '0;
    p4      = '0;
    p8      = '0;
    t       = '0;
    res_d   = res_q;
    mode2_d = (adv2 && v1_q) ? mode1_q : mode2_q;
    v2_d    = adv2 ? v1_q : v2_q;
    if (adv2 && v1_q) begin
      for (int k = 0; k < NB; k++) begin
        p2 = '0;
        p4 = '0;
        p8 = '0;
        // Lane products never exceed their 2L-bit field, so shared accumulators stay lane-clean
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            t  = 16'(pp_q[((k*4+i)*4+j)*4 +: 4]) << (2 * (i + j));
            p8 = p8 + t;
            p4 = (i / 2 == j / 2) ? p4 + t : p4;
            p2 = (i == j) ? p2 + t : p2;
          end
        for (int h = 0; h < 4; h++) p2[h*4 +: 4] = p2[h*4 +: 4] + corr_q[k*16+h*4 +: 4];
        for (int h = 0; h < 2; h++) p4[h*8 +: 8] = p4[h*8 +: 8] + corr_q[k*16+h*8 +: 8];
        p8 = p8 + corr_q[k*16 +: 16];
        res_d[k*16 +: 16] = mode1_q[1] ? p8 : mode1_q[0] ? p4 : p2;
      end
    end
  end
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      pp_q    <= '0;
      corr_q  <= '0;
      mode1_q <= '0;
      v1_q    <= 1'b0;
      res_q   <= '0;
      mode2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      pp_q    <= pp_d;
      corr_q  <= corr_d;
      mode1_q <= mode1_d;
      v1_q    <= v1_d;
      res_q   <= res_d;
      mode2_q <= mode2_d;
      v2_q    <= v2_d;
    end
  end
  assign result    = res_q;
  assign out_mode  = mode2_q;
  assign out_valid = v2_q;
endmodule

// File: tb/tb_simd_multiplier.sv
// tb_simd_multiplier: directed + random scoreboard bench for simd_multiplier (WIDTH=8).
module tb_simd_multiplier;
  logic        CLK = 1'b0, nrst = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [1:0]  mode = '0;
  logic        sgn = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] result;
  logic [1:0]  out_mode;
  typedef struct packed {logic [15:0] r; logic [1:0] m;} exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          vec_cnt = 0, err_cnt = 0, cyc = 0;
  int          ret_cyc[$];
  logic        hold = 1'b0, rnd_bp = 1'b0;
  logic [15:0] hres;
  logic [1:0]  hmode;

  simd_multiplier #(.WIDTH(8)) dut (
    .CLK(CLK), .nrst(nrst), .a(a), .b(b), .mode(mode),
`ifdef SIMD_MULT_SIGNED_EN
    .sgn(sgn),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_mode(out_mode), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Reference model: direct per-lane multiplication in integer arithmetic
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input logic s);
    int l, xv, yv, p;
    logic [15:0] r;
    l = m[1] ? 8 : (m[0] ? 4 : 2);
    r = '0;
    for (int i = 0; i < 8 / l; i++) begin
      xv = (int'(x) >> (i * l)) & ((1 << l) - 1);
      yv = (int'(y) >> (i * l)) & ((1 << l) - 1);
      if (s && xv >= (1 << (l - 1))) xv = xv - (1 << l);
      if (s && yv >= (1 << (l - 1))) yv = yv - (1 << l);
      p = xv * yv;
      r = r | 16'((p & ((1 << (2 * l)) - 1)) << (i * 2 * l));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!nrst) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", 32'(result), 32'(hres));
        chk("hold_mode", 32'(out_mode), 32'(hmode));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.r));
          chk("out_mode", 32'(out_mode), 32'(e.m));
          ret_cyc.push_back(cyc);
        end
      end
      hold = out_valid && !out_ready;
      hres = result;
      hmode = out_mode;
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input logic s);
    bit ok = 1'b0;
    a = x; b = y; mode = m; sgn = s; in_valid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
      if (ok) sb.push_back('{r: model(x, y, m, s), m: m});
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() > 0; n++) @(posedge CLK);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic one(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [1:0] m, input logic s, input logic [15:0] exp);
    send(x, y, m, s);
    chk({tag, "_lat0"}, 32'(out_valid), 32'd0);
    @(posedge CLK);
    #1;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(result), 32'(exp));
    chk({tag, "_mode"}, 32'(out_mode), 32'(m));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic sg;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #3 nrst = 1'b1;
    @(posedge CLK); #1 out_ready = 1'b1;
    one("m2_ffxff", 8'hFF, 8'hFF, 2'b00, 1'b0, 16'h9999);
    one("m4_33x21", 8'h33, 8'h21, 2'b01, 1'b0, 16'h0603);
    one("m8_ffxff", 8'hFF, 8'hFF, 2'b10, 1'b0, 16'hFE01);
    one("m11_alias", 8'hFF, 8'hFF, 2'b11, 1'b0, 16'hFE01);
    one("m4_fxf", 8'hFF, 8'hFF, 2'b01, 1'b0, 16'hE1E1);
    ret_cyc.delete();
    send(8'h03, 8'h03, 2'b10, 1'b0);
    send(8'hFF, 8'hFF, 2'b00, 1'b0);
    send(8'h33, 8'h21, 2'b01, 1'b0);
    drain();
    chk("b2b_count", 32'(ret_cyc.size()), 32'd3);
    if (ret_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(ret_cyc[1] - ret_cyc[0]), 32'd1);
      chk("b2b_gap2", 32'(ret_cyc[2] - ret_cyc[1]), 32'd1);
    end
    out_ready = 1'b0;
    send(8'h03, 8'h03, 2'b10, 1'b0);
    send(8'hFF, 8'hFF, 2'b00, 1'b0);
    a = 8'h33; b = 8'h21; mode = 2'b01; in_valid = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'h0009);
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    send(8'h33, 8'h21, 2'b01, 1'b0);
    drain();
    rnd_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
`ifdef SIMD_MULT_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), sg);
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();
    send(8'hFF, 8'hFF, 2'b10, 1'b0);
    @(posedge CLK); #1;
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_mode", 32'(out_mode), 32'd0);
    sb.delete();
    out_ready = 1'b0;
    @(posedge CLK); #3 nrst = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    one("post_rst_m4", 8'h33, 8'h21, 2'b01, 1'b0, 16'h0603);
`ifdef SIMD_MULT_SIGNED_EN
    one("s2_ffxff", 8'hFF, 8'hFF, 2'b00, 1'b1, 16'h1111);
    one("s8_80x80", 8'h80, 8'h80, 2'b10, 1'b1, 16'h4000);
    one("s4_f7x13", 8'hF7, 8'h13, 2'b01, 1'b1, 16'hFF15);
    one("s8_ffx02", 8'hFF, 8'h02, 2'b10, 1'b1, 16'hFFFE);
    send(8'hFF, 8'hFF, 2'b00, 1'b1);
    @(posedge CLK); #2 nrst = 1'b0;
    #1 chk("s_mid_rst_valid", 32'(out_valid), 32'd0);
    sb.delete();
    @(posedge CLK); #3 nrst = 1'b1;
    #1 chk("s_post_rst_in_ready", 32'(in_ready), 32'd1);
`endif
    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
